lsu_load_ctrl: RTL and testbench

//  Load-side memory access controller; sits directly upstream of the load data sign/zero-extension stage.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align_shift.sv | 39 +++
 rtl/lsu_load_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_load_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and constants for the load-side LSU controller:
//            FSM state encoding, result error codes and RV32I load func3
//            values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Result error codes reported on out_err
  localparam logic [1:0] LSU_OK       = 2'd0;
  localparam logic [1:0] LSU_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_BUS      = 2'd2;
  localparam logic [1:0] LSU_TIMEOUT  = 2'd3;

  // RV32I load func3 encodings
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

endpackage

`default_nettype wire

// File: rtl/lsu_align_shift.sv
// ============================================================================
// Module   : lsu_align_shift
// Purpose  : Combinational byte-lane alignment and misalignment detection.
//            Shifts the returned bus word right by 8*offset (zero fill) so
//            the addressed byte/half lands at bit 0, and flags accesses whose
//            offset is illegal for the access size.
// Ports    : i_rdata    [31:0] bus word
//            i_off      [1:0]  byte offset within the word
//            i_func3    [2:0]  RV32I load func3
//            o_data     [31:0] i_rdata >> (8*i_off)
//            o_misalign        1 when the access violates natural alignment
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align_shift
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data,
  output logic        o_misalign
);

  always_comb begin
    o_data     = i_rdata >> {i_off, 3'b000};
    o_misalign = 1'b0;
    case (i_func3)
      LB, LBU: o_misalign = 1'b0;
      LH, LHU: o_misalign = i_off[0];
      // lw and the unsupported encodings 3/6/7 all need word alignment
      default: o_misalign = |i_off;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_load_ctrl.sv
// ============================================================================
// Module   : lsu_load_ctrl
// Purpose  : Load-side memory access controller. Accepts one load request at
//            a time, checks alignment, issues an AXI4-Lite read, lane-aligns
//            the returned word and presents {data, func3, rd, err} to the
//            extension stage over valid/ready. All outputs are registered.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready/in_addr/in_func3/in_rd  - request from EXU
//            araddr/arvalid/arready                   - AXI AR channel
//            rdata/rresp/rvalid/rready                - AXI R channel
//            out_valid/out_ready/out_data/out_func3/out_rd/out_err - result
// Config   : define LSU_TIMEOUT_EN to enable the R-channel watchdog
//            (TIMEOUT cycles, reports err=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [2:0]        in_func3,
  input  logic [RD_W-1:0]   in_rd,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_func3,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        out_err
);

  lsu_state_e        r_state;
  logic [1:0]        r_off;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [2:0]        r_out_func3;
  logic [RD_W-1:0]   r_out_rd;
  logic [1:0]        r_out_err;

  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_shifted;
  logic              w_misalign;

`ifdef LSU_TIMEOUT_EN
  localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TMO_LIM = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] r_tmo_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // One shared aligner: in IDLE it checks the incoming address, afterwards
  // it shifts the R data by the latched offset.
  assign w_off = (r_state == ST_IDLE) ? in_addr[1:0] : r_off;

  lsu_align_shift u_align (
    .i_rdata    (rdata),
    .i_off      (w_off),
    .i_func3    (in_func3),
    .o_data     (w_shifted),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_off       <= '0;
      r_in_ready  <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_func3 <= '0;
      r_out_rd    <= '0;
      r_out_err   <= LSU_OK;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          // Gate on the registered ready so nothing is taken in the first
          // cycle after reset release.
          if (in_valid && r_in_ready) begin
            r_in_ready  <= 1'b0;
            r_off       <= in_addr[1:0];
            r_out_func3 <= in_func3;
            r_out_rd    <= in_rd;
            r_out_data  <= '0;
            if (w_misalign) begin
              r_out_err   <= LSU_MISALIGN;
              r_out_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_out_err <= LSU_OK;
              r_araddr  <= {in_addr[ADDR_W-1:2], 2'b00};
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end

        ST_R: begin
          if (rvalid) begin
            // Data is shifted even on an error response
            r_out_data  <= w_shifted;
            r_out_err   <= (rresp != 2'b00) ? LSU_BUS : LSU_OK;
            r_rready    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_tmo_cnt == C_TMO_LIM) begin
            r_out_data  <= '0;
            r_out_err   <= LSU_TIMEOUT;
            r_rready    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign araddr    = r_araddr;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_func3 = r_out_func3;
  assign out_rd    = r_out_rd;
  assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_load_ctrl.sv
// ============================================================================
// Module   : tb_lsu_load_ctrl
// Purpose  : Directed self-checking bench for lsu_load_ctrl. The AXI slave
//            and EXU/WBU sides are driven directly from one linear sequence.
//            Define LSU_TIMEOUT_EN to exercise the watchdog path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [2:0]  in_func3;
  logic [4:0]  in_rd;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_func3;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_load_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RD_W    (5),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_func3  (in_func3),
    .in_rd     (in_rd),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_func3 (out_func3),
    .out_rd    (out_rd),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one clock edge (caller ensures in_ready=1).
  task automatic accept(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    in_valid = 1'b1;
    in_addr  = a;
    in_func3 = f3;
    in_rd    = rd;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_func3  = '0;
    in_rd     = '0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = '0;
    rvalid    = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset ----------------
    step();
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_arvalid",   {31'd0, arvalid},   32'd0);
    chk("rst_rready",    {31'd0, rready},    32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_araddr",    araddr,             32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_err",   {30'd0, out_err},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // ---------------- 1: aligned lw, all readies high ----------------
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00; out_ready = 1'b1;
    accept(32'h8000_0004, 3'd2, 5'd7);
    chk("t1_arvalid",  {31'd0, arvalid},  32'd1);
    chk("t1_araddr",   araddr,            32'h8000_0004);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
    chk("t1_rready",       {31'd0, rready},  32'd1);
    step();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data",  out_data,           32'hDEADBEEF);
    chk("t1_out_err",   {30'd0, out_err},   32'd0);
    chk("t1_out_rd",    {27'd0, out_rd},    32'd7);
    chk("t1_out_func3", {29'd0, out_func3}, 32'd2);
    chk("t1_rready_drop", {31'd0, rready},  32'd0);
    step();
    chk("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_in_ready_back",  {31'd0, in_ready},  32'd1);

    // ---------------- 2: lbu at offset 3 ----------------
    rdata = 32'h11223344;
    accept(32'h8000_0003, 3'd4, 5'd9);
    chk("t2_araddr", araddr, 32'h8000_0000);
    step();
    step();
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_out_data",  out_data,           32'h0000_0011);
    chk("t2_out_func3", {29'd0, out_func3}, 32'd4);
    chk("t2_out_rd",    {27'd0, out_rd},    32'd9);
    step();
    chk("t2_in_ready_back", {31'd0, in_ready}, 32'd1);

    // ---------------- 3: misaligned lh ----------------
    accept(32'h8000_0001, 3'd1, 5'd3);
    chk("t3_arvalid",   {31'd0, arvalid},   32'd0);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out_err",   {30'd0, out_err},   32'd1);
    chk("t3_out_data",  out_data,           32'd0);
    chk("t3_in_ready",  {31'd0, in_ready},  32'd0);
    step();
    chk("t3_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t3_arvalid_after",  {31'd0, arvalid},   32'd0);
    chk("t3_in_ready_back",  {31'd0, in_ready},  32'd1);

    // ---------------- 4: bus error, back-pressure on result ----------------
    rdata = 32'hCAFEF00D; rresp = 2'b10; out_ready = 1'b0;
    accept(32'h8000_0008, 3'd2, 5'd12);
    step();
    step();
    chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out_err",   {30'd0, out_err},   32'd2);
    chk("t4_out_data",  out_data,           32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data",  out_data,           32'hCAFEF00D);
      chk("t4_hold_err",   {30'd0, out_err},   32'd2);
      chk("t4_hold_rd",    {27'd0, out_rd},    32'd12);
      chk("t4_hold_inrdy", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t4_in_ready_back",  {31'd0, in_ready},  32'd1);
    rresp = 2'b00;

    // ---------------- 5: AR and R stalls, lhu at offset 2 ----------------
    arready = 1'b0; rvalid = 1'b0; rdata = 32'hAABBCCDD;
    accept(32'h8000_0012, 3'd5, 5'd21);
    chk("t5_arvalid", {31'd0, arvalid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_ar_hold_valid", {31'd0, arvalid}, 32'd1);
      chk("t5_ar_hold_addr",  araddr,           32'h8000_0010);
      chk("t5_ar_no_rready",  {31'd0, rready},  32'd0);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t5_ar_done",    {31'd0, arvalid}, 32'd0);
    chk("t5_rready",     {31'd0, rready},  32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_r_no_dup_ar", {31'd0, arvalid},   32'd0);
      chk("t5_r_hold",      {31'd0, rready},    32'd1);
      chk("t5_r_no_valid",  {31'd0, out_valid}, 32'd0);
    end
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_out_data",  out_data,           32'h0000_AABB);
    chk("t5_out_err",   {30'd0, out_err},   32'd0);
    chk("t5_out_func3", {29'd0, out_func3}, 32'd5);
    step();
    chk("t5_in_ready_back", {31'd0, in_ready}, 32'd1);

    // ---------------- 6: R channel never answers ----------------
    arready = 1'b1; rvalid = 1'b0;
    accept(32'h8000_0020, 3'd2, 5'd30);
    step();
    chk("t6_rready", {31'd0, rready}, 32'd1);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_wait_no_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_wait_rready",   {31'd0, rready},    32'd1);
    end
    step();
    chk("t6_tmo_valid",  {31'd0, out_valid}, 32'd1);
    chk("t6_tmo_err",    {30'd0, out_err},   32'd3);
    chk("t6_tmo_data",   out_data,           32'd0);
    chk("t6_tmo_rready", {31'd0, rready},    32'd0);
    step();
    chk("t6_tmo_in_ready_back", {31'd0, in_ready}, 32'd1);
    // Second run: reach R again, then reset in the middle of it
    accept(32'h8000_0024, 3'd2, 5'd31);
    step();
    step();
    step();
    chk("t6b_in_r", {31'd0, rready}, 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_wait_no_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_wait_rready",   {31'd0, rready},    32'd1);
    end
`endif
    // Asynchronous reset away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_rready",    {31'd0, rready},    32'd0);
    chk("t6_arst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("t6_arst_araddr",    araddr,             32'd0);
    chk("t6_arst_out_rd",    {27'd0, out_rd},    32'd0);
    chk("t6_arst_out_func3", {29'd0, out_func3}, 32'd0);
    chk("t6_arst_out_valid", {31'd0, out_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    chk("t6_rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // ---------------- recovery: lb at offset 2 ----------------
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h11223344; out_ready = 1'b1;
    accept(32'h8000_0032, 3'd0, 5'd1);
    chk("t7_araddr", araddr, 32'h8000_0030);
    step();
    step();
    chk("t7_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t7_out_data",  out_data,           32'h0000_1122);
    chk("t7_out_err",   {30'd0, out_err},   32'd0);
    step();
    chk("t7_in_ready_back", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
